// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one memory read per doFetch and
// latches the returned word, faulting on timeout or a misaligned branch target.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        doFetch,
  input  logic        doNext,
  input  logic        doReset,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memAck,
  input  logic [31:0] memData,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        fetchDone,
  output logic        fetchBusy,
  output logic        fetchError
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    DONE  = 2'b10,
    ERROR = 2'b11
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bad_branch;

  assign bad_branch = doNext && branchTaken && (branchTarget[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      instr_q <= 32'h0;
      cnt_q   <= 8'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // doReset overrides every state, including an ack arriving in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bad_branch)   state_d = ERROR;
        else if (doFetch) state_d = REQ;
      end
      REQ: begin
        if (memAck)                 state_d = DONE;
        else if (cnt_q == CNT_LAST) state_d = ERROR;
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
    if (doReset) state_d = IDLE;
  end

  // PC update lands on the same edge as IDLE->REQ, so the fetch sees the new PC
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    if (doReset) begin
      pc_d    = RESET_VECTOR;
      instr_d = 32'h0;
      cnt_d   = 8'h0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = 8'h0;
          if (doNext && !bad_branch)
            pc_d = branchTaken ? branchTarget : pc_q + 32'd4;
        end
        REQ: begin
          if (memAck) instr_d = memData;
          else        cnt_d   = cnt_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    memReq     = (state_q == REQ);
    fetchDone  = (state_q == DONE);
    fetchBusy  = (state_q != IDLE);
    fetchError = (state_q == ERROR);
  end

  assign memAddr     = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected instruction words are queued when
// memory acks and compared when fetchDone is seen.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rstN;
  logic        doFetch, doNext, doReset, branchTaken;
  logic [31:0] branchTarget;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memData;
  logic [31:0] pc, instruction;
  logic        fetchDone, fetchBusy, fetchError;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [31:0] sb[$];

  fetch_unit #(.RESET_VECTOR(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .rstN(rstN), .doFetch(doFetch), .doNext(doNext),
    .doReset(doReset), .branchTaken(branchTaken), .branchTarget(branchTarget),
    .memReq(memReq), .memAddr(memAddr), .memAck(memAck), .memData(memData),
    .pc(pc), .instruction(instruction), .fetchDone(fetchDone),
    .fetchBusy(fetchBusy), .fetchError(fetchError)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and settle; any fetchDone pulse is scored against the queue.
  task automatic tick();
    logic [31:0] exp;
    @(posedge clk);
    #1;
    if (fetchDone) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp = sb.pop_front();
        check("sb_instruction", instruction, exp);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_addr"}, memAddr, 32'h0);
    check({tag, "_instr"}, instruction, 32'h0);
    check({tag, "_memReq"}, {31'h0, memReq}, 32'h0);
    check({tag, "_done"}, {31'h0, fetchDone}, 32'h0);
    check({tag, "_busy"}, {31'h0, fetchBusy}, 32'h0);
    check({tag, "_err"}, {31'h0, fetchError}, 32'h0);
  endtask

  task automatic do_next(input logic br, input logic [31:0] tgt);
    doNext = 1'b1; branchTaken = br; branchTarget = tgt;
    tick();
    doNext = 1'b0; branchTaken = 1'b0; branchTarget = 32'h0;
  endtask

  initial begin
    int req_cycles;
    int done_before;
    rstN = 1'b0; doFetch = 1'b0; doNext = 1'b0; doReset = 1'b0;
    branchTaken = 1'b0; branchTarget = 32'h0; memAck = 1'b0; memData = 32'h0;
    #3;
    check_reset_outputs("por");
    @(posedge clk); #1;
    rstN = 1'b1;
    tick();
    check("idle_busy", {31'h0, fetchBusy}, 32'h0);

    // Zero-wait fetch
    doFetch = 1'b1;
    tick();
    doFetch = 1'b0;
    check("zw_memReq", {31'h0, memReq}, 32'h1);
    check("zw_addr", memAddr, 32'h0);
    check("zw_busy", {31'h0, fetchBusy}, 32'h1);
    memAck = 1'b1; memData = 32'hDEAD_BEEF; sb.push_back(32'hDEAD_BEEF);
    tick();
    memAck = 1'b0; memData = 32'h0;
    check("zw_done", {31'h0, fetchDone}, 32'h1);
    tick();
    check("zw_idle_busy", {31'h0, fetchBusy}, 32'h0);
    check("zw_done_once", {31'h0, fetchDone}, 32'h0);

    // Ack after five wait cycles; doNext/doFetch during REQ ignored
    doFetch = 1'b1;
    tick();
    doFetch = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (memReq) req_cycles++;
      if (i == 1) begin doNext = 1'b1; doFetch = 1'b1; end
      else begin doNext = 1'b0; doFetch = 1'b0; end
      tick();
    end
    doNext = 1'b0; doFetch = 1'b0;
    if (memReq) req_cycles++;
    memAck = 1'b1; memData = 32'h1234_5678; sb.push_back(32'h1234_5678);
    tick();
    check("wait_req_cycles", req_cycles, 32'd6);
    check("wait_done", {31'h0, fetchDone}, 32'h1);
    check("wait_busy_in_done", {31'h0, fetchBusy}, 32'h1);
    check("wait_pc_kept", pc, 32'h0);
    memData = 32'h5555_AAAA;   // ack still high outside REQ
    tick();
    check("wait_busy_end", {31'h0, fetchBusy}, 32'h0);
    tick();
    memAck = 1'b0;
    check("ack_idle_ignored", instruction, 32'h1234_5678);
    check("ack_idle_no_req", {31'h0, memReq}, 32'h0);
    check("wait_done_count", done_cnt, 32'd2);

    // Timeout into ERROR
    doFetch = 1'b1;
    tick();
    doFetch = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 40 && !fetchError; i++) begin
      if (memReq) req_cycles++;
      tick();
    end
    check("to_req_cycles", req_cycles, 32'd16);
    check("to_err", {31'h0, fetchError}, 32'h1);
    check("to_memReq_low", {31'h0, memReq}, 32'h0);
    doFetch = 1'b1;
    tick();
    doFetch = 1'b0;
    check("err_fetch_ignored", {31'h0, memReq}, 32'h0);
    check("err_sticky", {31'h0, fetchError}, 32'h1);
    do_next(1'b0, 32'h0);
    check("err_next_ignored", pc, 32'h0);
    doReset = 1'b1;
    tick();
    doReset = 1'b0;
    check_reset_outputs("softrst");

    // PC arithmetic and branch alignment
    do_next(1'b1, 32'hFFFF_FFFC);
    check("pc_branch_top", pc, 32'hFFFF_FFFC);
    do_next(1'b0, 32'h0);
    check("pc_wrap", pc, 32'h0);
    do_next(1'b1, 32'h0000_0100);
    check("pc_branch", pc, 32'h0000_0100);
    do_next(1'b1, 32'h0000_0102);
    check("misalign_err", {31'h0, fetchError}, 32'h1);
    check("misalign_pc", pc, 32'h0000_0100);
    doReset = 1'b1;
    tick();
    doReset = 1'b0;
    check("misalign_clear", {31'h0, fetchError}, 32'h0);

    // doReset with ack in the same REQ cycle drops the data
    doFetch = 1'b1;
    tick();
    doFetch = 1'b0;
    memAck = 1'b1; memData = 32'hA5A5_0001; sb.push_back(32'hA5A5_0001);
    tick();
    memAck = 1'b0;
    tick();
    doFetch = 1'b1;
    tick();
    doFetch = 1'b0;
    done_before = done_cnt;
    memAck = 1'b1; memData = 32'hCAFE_F00D; doReset = 1'b1;
    tick();
    memAck = 1'b0; doReset = 1'b0;
    check("rstack_no_done", {31'h0, fetchDone}, 32'h0);
    check("rstack_instr", instruction, 32'h0);
    check("rstack_memReq", {31'h0, memReq}, 32'h0);
    tick();
    check("rstack_done_count", done_cnt, done_before);

    // Simultaneous doNext + doFetch, then async reset mid-REQ
    do_next(1'b1, 32'h0000_0008);
    doNext = 1'b1; doFetch = 1'b1;
    tick();
    doNext = 1'b0; doFetch = 1'b0;
    check("nf_addr", memAddr, 32'h0000_000C);
    check("nf_memReq", {31'h0, memReq}, 32'h1);
    tick();
    memAck = 1'b1; memData = 32'h0BAD_0BAD;
    done_before = done_cnt;
    #2 rstN = 1'b0;
    #1;
    check_reset_outputs("async");
    #1 rstN = 1'b1;
    tick();
    memAck = 1'b0;
    tick();
    check("async_no_done", done_cnt, done_before);
    check("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL set the PC value loaded on reset and doReset.
REQ-002 Parameter TIMEOUT, default 16, range 2..255, SHALL set the maximum number of memReq cycles allowed before a fetch fault.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rstN  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 doFetch  in  1  SHALL be the fetch-start strobe from control.
REQ-006 doNext  in  1  SHALL be the PC-advance strobe from control.
REQ-007 doReset  in  1  SHALL be the synchronous soft reset from control.
REQ-008 branchTaken  in  1  SHALL select branchTarget as the next PC.
REQ-009 branchTarget  in  32  SHALL be the branch destination address.
REQ-010 memReq  out  1  SHALL be the instruction-memory read request.
REQ-011 memAddr  out  32  SHALL be the read address, equal to pc.
REQ-012 memAck  in  1  SHALL indicate memData is valid for the current request.
REQ-013 memData  in  32  SHALL be the instruction word from memory.
REQ-014 pc  out  32  SHALL be the current program counter.
REQ-015 instruction  out  32  SHALL be the last fetched instruction word.
REQ-016 fetchDone  out  1  SHALL be a one-cycle completion pulse to control.
REQ-017 fetchBusy  out  1  SHALL be high whenever the state is not IDLE.
REQ-018 fetchError  out  1  SHALL be the sticky fault flag.

Function
REQ-019 FSM states SHALL be IDLE, REQ, DONE, ERROR, fully encoded with no unreachable legal transitions.
REQ-020 IDLE: doFetch -> REQ; timeout counter cleared.
REQ-021 REQ: memReq=1; memAck sampled high at an edge -> instruction<=memData, -> DONE.
REQ-022 REQ: no memAck -> counter increments; at TIMEOUT cycles in REQ without memAck -> ERROR, so memReq stays high at most TIMEOUT cycles.
REQ-023 DONE: fetchDone=1 for exactly that cycle, then -> IDLE unconditionally.
REQ-024 ERROR: memReq=0, fetchError=1; doFetch and doNext ignored; exit only via doReset or rstN.
REQ-025 Zero-wait latency: doFetch sampled at edge 0, memReq high in cycle 1, memAck in cycle 1 -> fetchDone high in cycle 2, IDLE in cycle 3.
REQ-026 doNext in IDLE: pc <= branchTaken ? branchTarget : pc+4, modulo 2^32 (32'hFFFF_FFFC+4 wraps to 0).
REQ-027 doNext with branchTaken=1 and branchTarget[1:0]!=0: pc unchanged, -> ERROR.
REQ-028 doNext and doFetch in the same IDLE cycle: pc advances and the fetch requests the updated pc.
REQ-029 doNext or doFetch while in REQ or DONE SHALL be ignored, with no queuing.
REQ-030 memAck while not in REQ SHALL be ignored.
REQ-031 doReset, highest priority in any state: pc<=RESET_VECTOR, instruction<=0, fetchError<=0, counter<=0, -> IDLE; memReq low from the next cycle.
REQ-032 doReset mid-REQ with memAck in the same cycle: memData discarded, no fetchDone.

Reset
REQ-033 rstN low SHALL immediately force: state IDLE, pc=RESET_VECTOR, instruction=0, memReq=0, fetchDone=0, fetchBusy=0, fetchError=0, counter=0.
REQ-034 After rstN deasserts, the first action SHALL occur on the first rising edge with doFetch or doNext high.

Verification
REQ-035 Reset, doFetch, memAck in first REQ cycle with memData=32'hDEAD_BEEF -> memAddr=0, fetchDone in cycle 2, instruction=32'hDEAD_BEEF.
REQ-036 doFetch, memAck delayed 5 cycles -> memReq high exactly 6 cycles, one fetchDone pulse, fetchBusy high until DONE ends.
REQ-037 doFetch, never ack, TIMEOUT=16 -> memReq high 16 cycles, then fetchError=1; doFetch ignored; doReset clears it and pc=RESET_VECTOR.
REQ-038 pc=32'hFFFF_FFFC, doNext -> pc=0; doNext with branchTaken=1, target 32'h100 -> pc=32'h100; target 32'h102 -> ERROR, pc unchanged.
REQ-039 Simultaneous doNext and doFetch at pc=8 -> memAddr=12; rstN pulsed low mid-REQ -> all outputs at reset values asynchronously, no fetchDone.
